// File: rtl/bit_stream_serializer_pkg.sv
// Shared types and constants for the bit-stream serializer and its FIFO.
package bit_stream_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int   DEF_WIDTH  = 8;
  localparam int   DEF_DEPTH  = 4;
  localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/bit_stream_serializer_sync_fifo.sv
// Synchronous FIFO with registered occupancy and registered ready.
// Ready is derived from the next level so it always matches the registered level.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int LVLW = $clog2(DEPTH + 1),
  localparam int PTRW = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [LVLW-1:0]  o_level,
  output logic             o_ready
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTRW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [LVLW-1:0]  r_level, w_level_nxt;
  logic             r_ready;
  logic             w_push, w_pop;

  // Requests are qualified here so neither overflow nor underflow can occur.
  assign w_push = i_push && r_ready;
  assign w_pop  = i_pop && (r_level != '0);

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop)      w_level_nxt = r_level + LVLW'(1);
    else if (!w_push && w_pop) w_level_nxt = r_level - LVLW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ready  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTRW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTRW'(1);
      r_level <= w_level_nxt;
      r_ready <= (w_level_nxt != LVLW'(DEPTH));
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_level = r_level;
  assign o_ready = r_ready;

endmodule

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial front end: FIFO-buffered words shifted out MSB first,
// back to back while data is queued, idle level otherwise.
module bit_stream_serializer
  import bit_stream_serializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int LVLW = $clog2(DEPTH + 1),
  localparam int CNTW = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_din_valid,
  output logic             o_din_ready,
  output logic             o_bit_out,
  output logic             o_bit_valid,
  output logic             o_last_bit,
  output logic [LVLW-1:0]  o_level
);

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [CNTW-1:0]  r_cnt, w_cnt_nxt;
  logic             r_bit, r_vld, r_last;
  logic             w_bit_nxt, w_vld_nxt, w_last_nxt;
  logic [WIDTH-1:0] w_head;
  logic [LVLW-1:0]  w_level;
  logic             w_load;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_din_valid),
    .i_data  (i_din),
    .i_pop   (w_load),
    .o_data  (w_head),
    .o_level (w_level),
    .o_ready (o_din_ready)
  );

  // Load from idle or at a word boundary, so consecutive words have no gap.
  assign w_load = (w_level != '0) && ((r_state == ST_IDLE) || (r_cnt == '0));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_bit   <= IDLE_LEVEL;
      r_vld   <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_vld   <= w_vld_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_load) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (r_cnt == '0 && !w_load) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = IDLE_LEVEL;
    w_vld_nxt   = 1'b0;
    w_last_nxt  = 1'b0;
    if (w_load) begin
      w_shift_nxt = w_head;
      w_cnt_nxt   = CNTW'(WIDTH - 1);
      w_bit_nxt   = w_head[WIDTH-1];
      w_vld_nxt   = 1'b1;
    end else if (r_state == ST_SHIFT && r_cnt != '0) begin
      w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
      w_cnt_nxt   = r_cnt - CNTW'(1);
      w_bit_nxt   = r_shift[WIDTH-2];
      w_vld_nxt   = 1'b1;
      w_last_nxt  = (r_cnt == CNTW'(1));
    end
  end

  assign o_bit_out   = r_bit;
  assign o_bit_valid = r_vld;
  assign o_last_bit  = r_last;
  assign o_level     = w_level;

endmodule
